// File: rtl/hps_sample_pkg.sv
// hps_sample_pkg
// Shared definitions for the HPS sample capture block:
//   - Avalon register word addresses (ADDR_DATA .. ADDR_TSTAMP)
//   - FIFO_STATUS bit positions and the FIFO-not-empty interrupt enable bit
//   - edge-capture mode enumeration (rising / falling / any)
package hps_sample_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CAP    = 3'd2;
    localparam logic [2:0] ADDR_FIFO_DATA   = 3'd3;
    localparam logic [2:0] ADDR_FIFO_STATUS = 3'd4;
    localparam logic [2:0] ADDR_TSTAMP      = 3'd5;

    localparam int STAT_EMPTY_BIT    = 16;
    localparam int STAT_FULL_BIT     = 17;
    localparam int STAT_OVF_BIT      = 18;
    localparam int MASK_FIFO_IRQ_BIT = 31;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/hps_sample_capture_if.sv
// hps_sample_capture_if
// Avalon-MM slave bus (read latency 1) for the HPS sample capture block.
//   address    : register word address
//   chipselect : slave select
//   read       : read strobe
//   write      : write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data
// Modports: master (HPS bridge / testbench side), slave (capture block side).
interface hps_sample_capture_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );

endinterface

// File: rtl/hps_sample_fifo.sv
// hps_sample_fifo
// Synchronous FIFO used to hold strobe-captured samples.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data
//   pop          : read request (ignored when empty)
//   dout         : head entry, valid whenever not empty
//   level        : number of stored entries, 0..DEPTH
//   empty, full  : status flags
// A push while full is accepted only if a pop happens in the same cycle.
module hps_sample_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update. When full with a simultaneous pop, the write lands in the
    // slot being vacated, which becomes the new tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; cleared on reset so no stale sample is ever visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/hps_sample_capture.sv
// hps_sample_capture
// Avalon-MM slave (read latency 1) that synchronises a DATA_W-bit sample bus,
// exposes its live value, captures per-bit edges with a maskable interrupt and
// queues samples taken on an external strobe.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus           : hps_sample_capture_if.slave (address/chipselect/read/write/
//                   writedata/readdata)
//   in_port       : asynchronous DATA_W-bit sample bus
//   sample_strobe : asynchronous capture request (rising edge pushes a sample)
//   irq           : registered level interrupt
// Optional feature macro: HPS_SAMPLE_TIMESTAMP_EN
//   defined   -> 16-bit free-running timestamp stored with each FIFO entry,
//                last popped timestamp readable at address 5
//   undefined -> no timestamp, address 5 reads 0
module hps_sample_capture
    import hps_sample_pkg::*;
#(
    parameter int DATA_W      = 9,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    hps_sample_capture_if.slave bus,
    input  logic [DATA_W-1:0]   in_port,
    input  logic                sample_strobe,
    output logic                irq
);

`ifdef HPS_SAMPLE_TIMESTAMP_EN
    localparam int FIFO_W = DATA_W + 16;
`else
    localparam int FIFO_W = DATA_W;
`endif

    logic [DATA_W-1:0]            data_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0]       strb_sync;
    logic [DATA_W-1:0]            sync_data;
    logic                         sync_strb;
    logic [DATA_W-1:0]            prev_data;
    logic                         prev_strb;
    logic [DATA_W-1:0]            edge_det;
    logic [DATA_W-1:0]            edge_capture;
    logic [DATA_W-1:0]            edge_clr;
    logic [DATA_W-1:0]            mask_edge;
    logic                         mask_fifo;
    logic                         overflow;
    logic                         wr_mask;
    logic                         wr_edge;
    logic                         wr_status;
    logic                         push_req;
    logic                         pop_req;
    logic [FIFO_W-1:0]            fifo_din;
    logic [FIFO_W-1:0]            fifo_dout;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic [15:0]                  tstamp_rd;
    logic [31:0]                  rd_mux;
    logic                         unused_wdata;

    assign unused_wdata = ^bus.writedata;

    // Synchroniser chains for the asynchronous sample bus and strobe; both use
    // the same depth so a strobe and its data arrive together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            strb_sync <= '0;
        end else begin
            data_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            strb_sync <= {strb_sync[SYNC_STAGES-2:0], sample_strobe};
        end
    end

    assign sync_data = data_sync[SYNC_STAGES-1];
    assign sync_strb = strb_sync[SYNC_STAGES-1];

    // Previous-cycle copies for edge detection. These reset to 0, so inputs
    // held high through reset show up as rising edges after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_data <= '0;
            prev_strb <= 1'b0;
        end else begin
            prev_data <= sync_data;
            prev_strb <= sync_strb;
        end
    end

    always_comb begin
        if (EDGE_TYPE == int'(EDGE_FALLING))
            edge_det = ~sync_data & prev_data;
        else if (EDGE_TYPE == int'(EDGE_ANY))
            edge_det = sync_data ^ prev_data;
        else
            edge_det = sync_data & ~prev_data;
    end

    assign wr_mask   = bus.chipselect & bus.write & (bus.address == ADDR_IRQ_MASK);
    assign wr_edge   = bus.chipselect & bus.write & (bus.address == ADDR_EDGE_CAP);
    assign wr_status = bus.chipselect & bus.write & (bus.address == ADDR_FIFO_STATUS);
    assign edge_clr  = wr_edge ? bus.writedata[DATA_W-1:0] : '0;

    assign push_req = sync_strb & ~prev_strb;
    assign pop_req  = bus.chipselect & bus.read & (bus.address == ADDR_FIFO_DATA) & ~fifo_empty;

    // Edge capture, interrupt mask and sticky overflow. A fresh edge is OR-ed
    // in after the W1C so it wins over a same-cycle clear; likewise overflow set
    // wins over its clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            mask_edge    <= '0;
            mask_fifo    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | edge_det;
            if (wr_mask) begin
                mask_edge <= bus.writedata[DATA_W-1:0];
                mask_fifo <= bus.writedata[MASK_FIFO_IRQ_BIT];
            end
            if (push_req && fifo_full && !pop_req)
                overflow <= 1'b1;
            else if (wr_status && bus.writedata[STAT_OVF_BIT])
                overflow <= 1'b0;
        end
    end

`ifdef HPS_SAMPLE_TIMESTAMP_EN
    logic [15:0] tstamp_cnt;
    logic [15:0] tstamp_latched;

    assign fifo_din  = {tstamp_cnt, sync_data};
    assign tstamp_rd = tstamp_latched;

    // Free-running timestamp; the head entry's stamp is kept when it is popped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tstamp_cnt     <= '0;
            tstamp_latched <= '0;
        end else begin
            tstamp_cnt <= tstamp_cnt + 16'd1;
            if (pop_req) tstamp_latched <= fifo_dout[FIFO_W-1:DATA_W];
        end
    end
`else
    assign fifo_din  = sync_data;
    assign tstamp_rd = '0;
`endif

    hps_sample_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop_req),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Register read mux; evaluated for the current address every cycle.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[DATA_W-1:0] = sync_data;
            ADDR_IRQ_MASK: begin
                rd_mux[DATA_W-1:0]        = mask_edge;
                rd_mux[MASK_FIFO_IRQ_BIT] = mask_fifo;
            end
            ADDR_EDGE_CAP: rd_mux[DATA_W-1:0] = edge_capture;
            ADDR_FIFO_DATA: begin
                if (!fifo_empty) rd_mux[DATA_W-1:0] = fifo_dout[DATA_W-1:0];
            end
            ADDR_FIFO_STATUS: begin
                rd_mux[15:0]           = 16'(fifo_level);
                rd_mux[STAT_EMPTY_BIT] = fifo_empty;
                rd_mux[STAT_FULL_BIT]  = fifo_full;
                rd_mux[STAT_OVF_BIT]   = overflow;
            end
            ADDR_TSTAMP: rd_mux[15:0] = tstamp_rd;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data and interrupt (one cycle behind their sources).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            irq          <= (|(edge_capture & mask_edge)) | (mask_fifo & ~fifo_empty);
        end
    end

endmodule

// File: doc/hps_sample_capture.md
Name: hps_sample_capture

Overview:
- Parametrised successor to the single-register HPS sample input port. Avalon-MM slave, read latency 1.
- Synchronises a DATA_W-bit sample bus into clk, keeps a live-value register, per-bit edge capture with a maskable interrupt, and a FIFO of samples taken on an external strobe.
- Sits between the citometer acquisition front end and the HPS lightweight bridge.

Parameters:
- DATA_W, 9, sample width; legal 1..31.
- FIFO_DEPTH, 16, FIFO entries; power of 2, 2..256.
- SYNC_STAGES, 2, synchroniser flops for in_port and sample_strobe; legal 2..4.
- EDGE_TYPE, 0, edge-capture mode: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- read  in  1  read strobe; pops FIFO only when qualified
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  DATA_W  asynchronous sample bus
- sample_strobe  in  1  asynchronous capture request
- irq  out  1  registered interrupt, level

Behaviour:
- Reset: clk and reset_n are fixed; reset_n is asynchronous, active-low.
- Reset asserted at any time, including mid-operation, clears every flop: synchronisers, prev, edge_capture, irq_mask, FIFO pointers, overflow, timestamp, readdata=0, irq=0.
- Synchronisers:
  - in_port and sample_strobe each pass through SYNC_STAGES flops to give sync_data and sync_strb.
  - prev_data and prev_strb hold the previous cycle's values.
- Register map (word address):
  - 0 DATA (RO): sync_data, zero-extended.
  - 1 IRQ_MASK (RW): bits [DATA_W-1:0] edge mask; bit31 enables the FIFO-not-empty interrupt; other bits read 0.
  - 2 EDGE_CAP (R/W1C): bit i set on a detected edge of sync_data[i] per EDGE_TYPE.
  - 3 FIFO_DATA (RO, pop): head sample zero-extended. Empty read returns 0 and does not pop.
  - 4 FIFO_STATUS: [15:0] level, [16] empty, [17] full, [18] overflow sticky. Writing 1 to bit18 clears overflow.
  - 5 TSTAMP: see Optional Feature.
  - 6-7: read 0, writes ignored.
- Read path:
  - readdata is registered and updated every clk with the mux output for the current address.
  - Valid the cycle after read&chipselect.
  - Pop = chipselect&read&address==3&!empty, single cycle.
- Edge capture:
  - Compares sync_data against prev_data. prev resets to 0, so an input held high through reset yields a rising edge about SYNC_STAGES+1 cycles after release; this is defined behaviour.
  - A new edge and a W1C of the same bit in the same cycle: the bit stays set.
- Push:
  - Rising edge of sync_strb (sync_strb & !prev_strb) pushes sync_data from the same cycle.
  - If full and no pop: sample dropped, overflow set. Overflow set beats clear in the same cycle.
  - Push and pop in the same cycle: both occur and level is unchanged. This holds when full (no overflow) and when level is 1.
  - A push when empty is readable at FIFO_DATA from the next cycle.
- Level range: 0..FIFO_DEPTH; full when level==FIFO_DEPTH.
- irq: registered; irq <= |(edge_capture & mask) | (mask[31] & !empty); one cycle latency from the condition.

Optional Feature:
- Macro HPS_SAMPLE_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running counter, reset 0, wraps 0xFFFF->0.
  - Each FIFO entry stores {timestamp, sample}; the FIFO width is DATA_W+16.
  - On pop, the entry's timestamp is latched into a register. Address 5 returns it in [15:0]; reset 0.
- Undefined:
  - No counter; the FIFO width is DATA_W.
  - Address 5 reads 0.

Decomposition:
- Package hps_sample_pkg holds:
  - register address constants ADDR_DATA..ADDR_TSTAMP;
  - status bit positions (STAT_EMPTY_BIT=16, STAT_FULL_BIT=17, STAT_OVF_BIT=18);
  - MASK_FIFO_IRQ_BIT=31 and edge-type enumerations.
- Sub-module hps_sample_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Signals: push, pop, dout = head, level, empty, full.
  - Uses log2(DEPTH)+1-bit pointers.

Test Plan:
- Reset, then in_port=0x1A5 held; read addr0 -> 0x000001A5 by SYNC_STAGES+2 cycles after the change. readdata=0 during reset.
- EDGE_TYPE=0, mask=0x001: toggle in_port[0] 0->1 -> EDGE_CAP=0x1 and irq=1. Write 0x1 to addr2 -> EDGE_CAP=0, irq=0. Repeat with the edge coinciding with the W1C -> bit stays 1.
- Pulse sample_strobe with data 0x011, 0x022, 0x033 -> status level=3. Three pops return 0x11, 0x22, 0x33. A 4th pop returns 0 with level=0 and empty=1.
- Fill 16 entries then pulse the strobe again -> full=1, overflow=1, level=16, head unchanged. Clear via bit18 -> overflow=0.
- With full, a strobe edge coinciding with a pop -> level stays 16, overflow stays 0, and the new sample lands at the tail.
- HPS_SAMPLE_TIMESTAMP_EN: strobe at counter 0xFFFE, then pop -> addr5=0xFFFE. Assert reset mid-fill -> level 0 and addr5=0 after release.
